// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register: decode control word, operands and indices to EXE, 1-cycle latency.
// Backpressure: freeze holds every field; flush/bubble insert invalid slots and bump a saturating counter.
// Optional feature macro: FWD_SRC_EN registers src1/src2 for the forwarding unit (tied to zero otherwise).
module id_exe_pipe_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             hazard,
    input  logic             cond_pass,
    input  logic [8:0]       ctrl_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] val_rn_in,
    input  logic [WIDTH-1:0] val_rm_in,
    input  logic             imm_in,
    input  logic [11:0]      shift_operand_in,
    input  logic [23:0]      simm24_in,
    input  logic [3:0]       dest_in,
    input  logic [3:0]       src1_in,
    input  logic [3:0]       src2_in,
    input  logic             carry_in,
    output logic [8:0]       ctrl_out,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] val_rn_out,
    output logic [WIDTH-1:0] val_rm_out,
    output logic             imm_out,
    output logic [11:0]      shift_operand_out,
    output logic [23:0]      simm24_out,
    output logic [3:0]       dest_out,
    output logic [3:0]       src1_out,
    output logic [3:0]       src2_out,
    output logic             carry_out,
    output logic             valid_out,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic [8:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] val_rn_q, val_rn_d;
    logic [WIDTH-1:0] val_rm_q, val_rm_d;
    logic             imm_q, imm_d;
    logic [11:0]      shift_operand_q, shift_operand_d;
    logic [23:0]      simm24_q, simm24_d;
    logic [3:0]       dest_q, dest_d;
    logic             carry_q, carry_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic             bubble;
    logic [CNT_W-1:0] bubble_cnt_inc;

    assign bubble         = hazard | ~cond_pass;
    assign bubble_cnt_inc = (&bubble_cnt_q) ? bubble_cnt_q : bubble_cnt_q + CNT_W'(1);

    // Flush beats freeze so a wrong-path instruction cannot survive a stall.
    always_comb begin
        ctrl_d          = ctrl_q;
        pc_d            = pc_q;
        val_rn_d        = val_rn_q;
        val_rm_d        = val_rm_q;
        imm_d           = imm_q;
        shift_operand_d = shift_operand_q;
        simm24_d        = simm24_q;
        dest_d          = dest_q;
        carry_d         = carry_q;
        valid_d         = valid_q;
        bubble_cnt_d    = bubble_cnt_q;
        if (flush) begin
            ctrl_d          = '0;
            pc_d            = '0;
            val_rn_d        = '0;
            val_rm_d        = '0;
            imm_d           = 1'b0;
            shift_operand_d = '0;
            simm24_d        = '0;
            dest_d          = '0;
            carry_d         = 1'b0;
            valid_d         = 1'b0;
            bubble_cnt_d    = bubble_cnt_inc;
        end else if (!freeze) begin
            // Bubbles still capture the datapath fields; only control and valid are killed.
            ctrl_d          = bubble ? 9'h000 : ctrl_in;
            pc_d            = pc_in;
            val_rn_d        = val_rn_in;
            val_rm_d        = val_rm_in;
            imm_d           = imm_in;
            shift_operand_d = shift_operand_in;
            simm24_d        = simm24_in;
            dest_d          = dest_in;
            carry_d         = carry_in;
            valid_d         = ~bubble;
            if (bubble) begin
                bubble_cnt_d = bubble_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q          <= '0;
            pc_q            <= '0;
            val_rn_q        <= '0;
            val_rm_q        <= '0;
            imm_q           <= 1'b0;
            shift_operand_q <= '0;
            simm24_q        <= '0;
            dest_q          <= '0;
            carry_q         <= 1'b0;
            valid_q         <= 1'b0;
            bubble_cnt_q    <= '0;
        end else begin
            ctrl_q          <= ctrl_d;
            pc_q            <= pc_d;
            val_rn_q        <= val_rn_d;
            val_rm_q        <= val_rm_d;
            imm_q           <= imm_d;
            shift_operand_q <= shift_operand_d;
            simm24_q        <= simm24_d;
            dest_q          <= dest_d;
            carry_q         <= carry_d;
            valid_q         <= valid_d;
            bubble_cnt_q    <= bubble_cnt_d;
        end
    end

`ifdef FWD_SRC_EN
    logic [3:0] src1_q, src1_d;
    logic [3:0] src2_q, src2_d;

    always_comb begin
        src1_d = src1_q;
        src2_d = src2_q;
        if (flush) begin
            src1_d = '0;
            src2_d = '0;
        end else if (!freeze) begin
            src1_d = src1_in;
            src2_d = src2_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src1_q <= '0;
            src2_q <= '0;
        end else begin
            src1_q <= src1_d;
            src2_q <= src2_d;
        end
    end

    assign src1_out = src1_q;
    assign src2_out = src2_q;
`else
    assign src1_out = 4'h0;
    assign src2_out = 4'h0;
`endif

    assign ctrl_out          = ctrl_q;
    assign pc_out            = pc_q;
    assign val_rn_out        = val_rn_q;
    assign val_rm_out        = val_rm_q;
    assign imm_out           = imm_q;
    assign shift_operand_out = shift_operand_q;
    assign simm24_out        = simm24_q;
    assign dest_out          = dest_q;
    assign carry_out         = carry_q;
    assign valid_out         = valid_q;
    assign bubble_cnt        = bubble_cnt_q;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Scoreboard bench for id_exe_pipe_reg (CNT_W=2 so counter saturation is reachable).
module tb_id_exe_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, hazard, cond_pass;
    logic [8:0]  ctrl_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic        imm_in, carry_in;
    logic [11:0] shift_operand_in;
    logic [23:0] simm24_in;
    logic [3:0]  dest_in, src1_in, src2_in;

    logic [8:0]  ctrl_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic        imm_out, carry_out, valid_out;
    logic [11:0] shift_operand_out;
    logic [23:0] simm24_out;
    logic [3:0]  dest_out, src1_out, src2_out;
    logic [1:0]  bubble_cnt;

    id_exe_pipe_reg #(.WIDTH(32), .CNT_W(2)) u_dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
        .cond_pass(cond_pass), .ctrl_in(ctrl_in), .pc_in(pc_in), .val_rn_in(val_rn_in),
        .val_rm_in(val_rm_in), .imm_in(imm_in), .shift_operand_in(shift_operand_in),
        .simm24_in(simm24_in), .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
        .carry_in(carry_in), .ctrl_out(ctrl_out), .pc_out(pc_out), .val_rn_out(val_rn_out),
        .val_rm_out(val_rm_out), .imm_out(imm_out), .shift_operand_out(shift_operand_out),
        .simm24_out(simm24_out), .dest_out(dest_out), .src1_out(src1_out),
        .src2_out(src2_out), .carry_out(carry_out), .valid_out(valid_out),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [31:0] pc, rn, rm;
        logic        imm;
        logic [11:0] shop;
        logic [23:0] simm;
        logic [3:0]  dest, src1, src2;
        logic        carry, valid;
        logic [1:0]  cnt;
    } exp_t;

    exp_t m = '0;
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   primed = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'd3) ? 2'd3 : c + 2'd1;
    endfunction

    task automatic rand_data();
        pc_in            = $urandom;
        val_rn_in        = $urandom;
        val_rm_in        = $urandom;
        imm_in           = 1'($urandom);
        shift_operand_in = 12'($urandom);
        simm24_in        = 24'($urandom);
        dest_in          = 4'($urandom);
        src1_in          = 4'($urandom);
        src2_in          = 4'($urandom);
        carry_in         = 1'($urandom);
        ctrl_in          = 9'($urandom);
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        exp_t e;
        logic bub;
        logic [1:0] c;
        #1;
        if (primed) begin
            check("no_comb_ctrl", 32'(ctrl_out), 32'(m.ctrl));
            check("no_comb_valid", 32'(valid_out), 32'(m.valid));
        end
        if (rst) begin
            m = '0;
        end else if (flush) begin
            c = m.cnt;
            m = '0;
            m.cnt = sat_inc(c);
        end else if (!freeze) begin
            bub    = hazard || !cond_pass;
            m.ctrl = bub ? 9'h000 : ctrl_in;
            m.pc   = pc_in;
            m.rn   = val_rn_in;
            m.rm   = val_rm_in;
            m.imm  = imm_in;
            m.shop = shift_operand_in;
            m.simm = simm24_in;
            m.dest = dest_in;
`ifdef FWD_SRC_EN
            m.src1 = src1_in;
            m.src2 = src2_in;
`endif
            m.carry = carry_in;
            m.valid = !bub;
            if (bub) m.cnt = sat_inc(m.cnt);
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("ctrl",   32'(ctrl_out),          32'(e.ctrl));
        check("pc",     pc_out,                 e.pc);
        check("val_rn", val_rn_out,             e.rn);
        check("val_rm", val_rm_out,             e.rm);
        check("imm",    32'(imm_out),           32'(e.imm));
        check("shop",   32'(shift_operand_out), 32'(e.shop));
        check("simm24", 32'(simm24_out),        32'(e.simm));
        check("dest",   32'(dest_out),          32'(e.dest));
        check("src1",   32'(src1_out),          32'(e.src1));
        check("src2",   32'(src2_out),          32'(e.src2));
        check("carry",  32'(carry_out),         32'(e.carry));
        check("valid",  32'(valid_out),         32'(e.valid));
        check("bcnt",   32'(bubble_cnt),        32'(e.cnt));
        primed = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; hazard = 1'b0; cond_pass = 1'b1;
        rand_data();
        ctrl_in = 9'h1FF;
        @(negedge clk);

        // Reset with all control bits set on the input
        repeat (2) cycle();

        // Normal load of a MOV
        rst = 1'b0;
        rand_data();
        ctrl_in = 9'h009; val_rm_in = 32'h0000_00AB; dest_in = 4'h3; src1_in = 4'h5;
        cycle();
        check("mov_ctrl", 32'(ctrl_out), 32'h009);
        check("mov_src1", 32'(src1_out),
`ifdef FWD_SRC_EN
              32'h5
`else
              32'h0
`endif
        );

        // Freeze for 3 cycles while inputs move
        freeze = 1'b1;
        repeat (3) begin
            rand_data();
            cycle();
        end
        check("frz_rm", val_rm_out, 32'hAB);
        freeze = 1'b0;

        // Bubbles on a STR word: hazard, then failed condition, then both
        rand_data();
        ctrl_in = 9'h00E; hazard = 1'b1;
        cycle();
        hazard = 1'b0; cond_pass = 1'b0; rand_data(); ctrl_in = 9'h00E;
        cycle();
        hazard = 1'b1; rand_data(); ctrl_in = 9'h00E;
        cycle();
        hazard = 1'b0; cond_pass = 1'b1;

        // Flush together with freeze
        rand_data();
        flush = 1'b1; freeze = 1'b1;
        cycle();
        flush = 1'b0; freeze = 1'b0;

        // Reset arriving during flush and freeze
        rand_data();
        rst = 1'b1; flush = 1'b1; freeze = 1'b1; hazard = 1'b1;
        cycle();
        rst = 1'b0; flush = 1'b0; freeze = 1'b0; hazard = 1'b0;

        // Saturation: five consecutive hazards from a cleared counter
        hazard = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            cycle();
            check("sat_seq", 32'(bubble_cnt), 32'(sat_exp[i]));
        end
        hazard = 1'b0;

        // Random mix of all controls
        for (int i = 0; i < 300; i++) begin
            rand_data();
            rst       = ($urandom_range(0, 19) == 0);
            flush     = ($urandom_range(0, 7) == 0);
            freeze    = ($urandom_range(0, 3) == 0);
            hazard    = ($urandom_range(0, 3) == 0);
            cond_pass = ($urandom_range(0, 4) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
